key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_pkg.sv | 26 ++
 rtl/key_event_decoder_if.sv | 21 ++
 rtl/key_event_decoder.sv | 140 ++++++++++++++
 tb/tb_key_event_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared state encoding and default timing constants for the key event decoder.
// Macro KEY_EVENT_DOUBLE_EN adds the WAIT2 state used for double-click detection.
package key_event_pkg;

    localparam int unsigned LONG_TIME_DEF   = 50_000_000;
    localparam int unsigned REPEAT_TIME_DEF = 10_000_000;
    localparam int unsigned DOUBLE_TIME_DEF = 12_500_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD,
`ifdef KEY_EVENT_DOUBLE_EN
        ST_WAIT2,
`endif
        ST_RELEASE
    } key_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key level in, event pulses and hold level out; master drives the key, slave decodes it.
interface key_event_decoder_if;

    logic click_n;
    logic short_p;
    logic long_p;
    logic repeat_p;
    logic double_p;
    logic hold_o;

    modport master (
        output click_n,
        input  short_p, long_p, repeat_p, double_p, hold_o
    );

    modport slave (
        input  click_n,
        output short_p, long_p, repeat_p, double_p, hold_o
    );

endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into short/long/repeat/double events (double needs KEY_EVENT_DOUBLE_EN).
// Latency: every pulse is registered, high for one cycle, in the cycle after the deciding sample.
// Backpressure: none; events are fire-and-forget pulses.
import key_event_pkg::*;

module key_event_decoder #(
    parameter int unsigned LONG_TIME   = LONG_TIME_DEF,
    parameter int unsigned REPEAT_TIME = REPEAT_TIME_DEF,
    parameter int unsigned DOUBLE_TIME = DOUBLE_TIME_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    key_event_decoder_if.slave  kif
);

    localparam int unsigned MAX_TIME = max3(LONG_TIME, REPEAT_TIME, DOUBLE_TIME);
    localparam int unsigned CW       = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TIME - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TIME - 1);
`ifdef KEY_EVENT_DOUBLE_EN
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_TIME - 1);
`endif

    key_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          prev_n;
    logic          press, key_up;
    logic          short_nxt, long_nxt, repeat_nxt;
`ifdef KEY_EVENT_DOUBLE_EN
    logic          double_nxt;
`endif

    // prev_n resets to 0 so a key held low through reset is not taken as a fresh press.
    assign press  = prev_n & ~kif.click_n;
    assign key_up = kif.click_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            prev_n       <= 1'b0;
            kif.short_p  <= 1'b0;
            kif.long_p   <= 1'b0;
            kif.repeat_p <= 1'b0;
            kif.hold_o   <= 1'b0;
`ifdef KEY_EVENT_DOUBLE_EN
            kif.double_p <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            prev_n       <= kif.click_n;
            kif.short_p  <= short_nxt;
            kif.long_p   <= long_nxt;
            kif.repeat_p <= repeat_nxt;
            kif.hold_o   <= (state_nxt == ST_HOLD);
`ifdef KEY_EVENT_DOUBLE_EN
            kif.double_p <= double_nxt;
`endif
        end
    end

`ifndef KEY_EVENT_DOUBLE_EN
    assign kif.double_p = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
`ifdef KEY_EVENT_DOUBLE_EN
        double_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_nxt = ST_PRESS;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS: begin
                if (key_up) begin
                    cnt_nxt = '0;
`ifdef KEY_EVENT_DOUBLE_EN
                    state_nxt = ST_WAIT2;
`else
                    short_nxt = 1'b1;
                    state_nxt = ST_IDLE;
`endif
                end else if (cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HOLD: begin
                if (key_up) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`ifdef KEY_EVENT_DOUBLE_EN
            // A second press wins over expiry when both land on the same sample.
            ST_WAIT2: begin
                if (press) begin
                    double_nxt = 1'b1;
                    state_nxt  = ST_RELEASE;
                    cnt_nxt    = '0;
                end else if (cnt == DOUBLE_LAST) begin
                    short_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`endif
            ST_RELEASE: begin
                if (key_up) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder against a timestamp-based event model.
module tb_key_event_decoder;

    localparam int L = 20;
    localparam int R = 5;
    localparam int D = 8;
`ifdef KEY_EVENT_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    key_event_decoder_if kif();

    key_event_decoder #(
        .LONG_TIME   (L),
        .REPEAT_TIME (R),
        .DOUBLE_TIME (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: time since press / time since release decide each event.
    int         e        = 0;
    int         press_at = -1;
    int         gap_from = -1;
    bit         second   = 1'b0;
    bit         pv       = 1'b0;
    logic [4:0] exp_vec  = '0;   // {short, long, repeat, double, hold}
    logic       stim[$];

    function automatic logic [4:0] dut_vec();
        return {kif.short_p, kif.long_p, kif.repeat_p, kif.double_p, kif.hold_o};
    endfunction

    task automatic model_reset();
        press_at = -1;
        gap_from = -1;
        second   = 1'b0;
        pv       = 1'b0;
        exp_vec  = '0;
    endtask

    task automatic model_edge(input logic c);
        bit fall;
        int el;
        fall    = pv && !c;
        exp_vec = '0;
        e++;
        if (press_at >= 0) begin
            el = e - press_at;
            if (c) begin
                if (el <= L) begin
                    if (DBL) gap_from = e;
                    else     exp_vec[4] = 1'b1;
                end
                press_at = -1;
            end else if (el == L) begin
                exp_vec[3] = 1'b1;
            end else if (el > L && ((el - L) % R) == 0) begin
                exp_vec[2] = 1'b1;
            end
        end else if (gap_from >= 0) begin
            if (fall) begin
                exp_vec[1] = 1'b1;
                gap_from   = -1;
                second     = 1'b1;
            end else if (e - gap_from == D) begin
                exp_vec[4] = 1'b1;
                gap_from   = -1;
            end
        end else if (second) begin
            if (c) second = 1'b0;
        end else if (fall) begin
            press_at = e;
        end
        exp_vec[0] = (press_at >= 0) && (e - press_at >= L);
        pv = c;
    endtask

    task automatic step(input logic lvl);
        kif.click_n = lvl;
        @(posedge clk);
        model_edge(lvl);
        @(negedge clk);
    endtask

    task automatic seg(input logic lvl, input int n);
        for (int i = 0; i < n; i++) stim.push_back(lvl);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        kif.click_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (dut_vec() !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec(), 5'b0);
        end
        rst_n = 1'b1;
        stim.delete();
        seg(1'b1, 4);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_idle step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_short();
        int short_n = 0, short_at = -1, other_n = 0;
        stim.delete();
        seg(1'b1, 2); seg(1'b0, 6); seg(1'b1, 20);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL short_model step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
            if (kif.short_p) begin short_n++; short_at = i; end
            if (kif.long_p || kif.repeat_p || kif.double_p) other_n++;
        end
        vectors++;
        if (short_n != 1 || short_at != (DBL ? 16 : 8) || other_n != 0) begin
            miscompares++;
            $display("FAIL short_timing got n=%0d at=%0d other=%0d exp n=1 at=%0d other=0",
                     short_n, short_at, other_n, DBL ? 16 : 8);
        end
    endtask

    task automatic test_double();
        int short_n = 0, dbl_n = 0, dbl_at = -1;
        stim.delete();
        seg(1'b1, 2); seg(1'b0, 6); seg(1'b1, 3); seg(1'b0, 4); seg(1'b1, 14);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL double_model step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
            if (kif.short_p) short_n++;
            if (kif.double_p) begin dbl_n++; dbl_at = i; end
        end
        vectors++;
        if (short_n != (DBL ? 0 : 2) || dbl_n != (DBL ? 1 : 0) || dbl_at != (DBL ? 11 : -1)) begin
            miscompares++;
            $display("FAIL double_timing got short=%0d dbl=%0d at=%0d exp short=%0d dbl=%0d at=%0d",
                     short_n, dbl_n, dbl_at, DBL ? 0 : 2, DBL ? 1 : 0, DBL ? 11 : -1);
        end
    endtask

    task automatic test_long_repeat();
        int long_at = -1, rep_n = 0, rep_first = -1, hold_n = 0, other_n = 0;
        stim.delete();
        seg(1'b1, 2); seg(1'b0, 36); seg(1'b1, 12);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL long_model step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
            if (kif.long_p) long_at = i;
            if (kif.repeat_p) begin rep_n++; if (rep_first < 0) rep_first = i; end
            if (kif.hold_o) hold_n++;
            if (kif.short_p || kif.double_p) other_n++;
        end
        vectors++;
        if (long_at != 22 || rep_n != 3 || rep_first != 27 || hold_n != 16 || other_n != 0) begin
            miscompares++;
            $display("FAIL long_timing got long=%0d rep=%0d first=%0d hold=%0d other=%0d exp 22 3 27 16 0",
                     long_at, rep_n, rep_first, hold_n, other_n);
        end
    endtask

    task automatic test_expiry_press();
        int short_n = 0, dbl_n = 0, dbl_at = -1;
        stim.delete();
        seg(1'b1, 2); seg(1'b0, 6); seg(1'b1, 8); seg(1'b0, 3); seg(1'b1, 14);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL expiry_model step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
            if (kif.short_p) short_n++;
            if (kif.double_p) begin dbl_n++; dbl_at = i; end
        end
        vectors++;
        if (short_n != (DBL ? 0 : 2) || dbl_n != (DBL ? 1 : 0) || dbl_at != (DBL ? 16 : -1)) begin
            miscompares++;
            $display("FAIL expiry_priority got short=%0d dbl=%0d at=%0d exp short=%0d dbl=%0d at=%0d",
                     short_n, dbl_n, dbl_at, DBL ? 0 : 2, DBL ? 1 : 0, DBL ? 16 : -1);
        end
    endtask

    task automatic test_reset_mid();
        int pulse_n = 0;
        stim.delete();
        seg(1'b1, 2); seg(1'b0, 6); seg(1'b1, 3);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL rstmid_pre step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
        end
        #2;
        kif.click_n = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_async got=%b exp=%b", dut_vec(), 5'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        seg(1'b0, 12); seg(1'b1, 2); seg(1'b0, 6); seg(1'b1, 20);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL rstmid_post step=%0d got=%b exp=%b", i, dut_vec(), exp_vec);
            end
            if (i < 14 && dut_vec() != 5'b0) pulse_n++;
        end
        vectors++;
        if (pulse_n != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet got=%0d active cycles exp=0", pulse_n);
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   n;
        for (int k = 0; k < 150; k++) begin
            lvl = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 30);
            for (int j = 0; j < n; j++) begin
                step(lvl);
                vectors++;
                if (dut_vec() !== exp_vec) begin
                    miscompares++;
                    $display("FAIL random k=%0d j=%0d got=%b exp=%b", k, j, dut_vec(), exp_vec);
                end
                vectors++;
                if ($countones(dut_vec() & 5'b11110) > 1) begin
                    miscompares++;
                    $display("FAIL random_exclusive got=%b exp at most one pulse", dut_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        kif.click_n = 1'b1;
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_expiry_press();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
